// File: rtl/prewish_mask_student_pkg.sv
// Shared definitions for the prewish mask receiver: player state encoding and default widths.
package prewish_mask_student_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_SYSCLK_DIV_BITS = 3;
  localparam int DEF_FIFO_AW         = 2;
  localparam int MASK_W              = 8;

endpackage

// File: rtl/prewish_mask_fifo.sv
// Synchronous FIFO for blink masks; head is the combinational read of the oldest entry.
module prewish_mask_fifo #(
  parameter int FIFO_AW = 2,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [W-1:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; pointers and count define validity, so the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  // count never exceeds DEPTH, so its top bit alone marks full.
  assign full  = count[FIFO_AW];
  assign empty = (count == '0);

endmodule

// File: rtl/prewish_mask_student.sv
// Mask-load receiver and LED player. Optional overrun counter: define PREWISH_OVERRUN_CNT_EN.
module prewish_mask_student
  import prewish_mask_student_pkg::*;
#(
  parameter int SYSCLK_DIV_BITS = DEF_SYSCLK_DIV_BITS,
  parameter int FIFO_AW         = DEF_FIFO_AW
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic [MASK_W-1:0] DAT_I,
  output logic              ACK_O,
  output logic              o_led,
  output logic              o_busy,
  output logic              o_full
`ifdef PREWISH_OVERRUN_CNT_EN
  ,
  output logic [7:0]        o_ovr_cnt
`endif
);

  logic                       stb_q;
  logic                       push_req;
  logic                       push;
  logic                       pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [MASK_W-1:0]          head;
  state_t                     state;
  logic [SYSCLK_DIV_BITS-1:0] presc;
  logic [2:0]                 bit_idx;
  logic [MASK_W-1:0]          shreg;
  logic                       bit_end;
  logic                       frame_end;

  assign push_req  = STB_I & ~stb_q;
  assign bit_end   = (presc == '1);
  assign frame_end = (state == ST_SHIFT) & bit_end & (bit_idx == 3'd0);
  assign pop       = ~fifo_empty & ((state == ST_IDLE) | frame_end);
  // A full queue still accepts when the player frees a slot in the same cycle.
  assign push      = push_req & (~fifo_full | pop);

  prewish_mask_fifo #(
    .FIFO_AW (FIFO_AW),
    .W       (MASK_W)
  ) u_fifo (
    .clk   (CLK_I),
    .rst_n (RST_I),
    .push  (push),
    .pop   (pop),
    .din   (DAT_I),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      stb_q <= 1'b0;
      ACK_O <= 1'b0;
    end else begin
      stb_q <= STB_I;
      ACK_O <= push;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state   <= ST_IDLE;
      presc   <= '0;
      bit_idx <= 3'd7;
      shreg   <= '0;
      o_led   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_led <= 1'b0;
          if (!fifo_empty) begin
            shreg   <= head;
            presc   <= '0;
            bit_idx <= 3'd7;
            o_led   <= head[MASK_W-1];
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          presc <= presc + 1'b1;
          if (bit_end) begin
            // bit_idx wraps 0 -> 7 at frame end, restarting the frame either way.
            bit_idx <= bit_idx - 1'b1;
            if (frame_end && !fifo_empty) begin
              shreg <= head;
              o_led <= head[MASK_W-1];
            end else begin
              shreg <= {shreg[MASK_W-2:0], shreg[MASK_W-1]};
              o_led <= shreg[MASK_W-2];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (state == ST_SHIFT);
  assign o_full = fifo_full;

`ifdef PREWISH_OVERRUN_CNT_EN
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      o_ovr_cnt <= 8'h00;
    end else if (push_req && !push && o_ovr_cnt != 8'hFF) begin
      o_ovr_cnt <= o_ovr_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_prewish_mask_student.sv
// Bench for prewish_mask_student: queue/frame reference model plus directed scenario checks.
module tb_prewish_mask_student;

  logic       clk;
  logic       rst_n;
  logic       stb;
  logic [7:0] dat;
  logic       ack;
  logic       led;
  logic       busy;
  logic       full;
`ifdef PREWISH_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  prewish_mask_student dut (
    .CLK_I  (clk),
    .RST_I  (rst_n),
    .STB_I  (stb),
    .DAT_I  (dat),
    .ACK_O  (ack),
    .o_led  (led),
    .o_busy (busy),
    .o_full (full)
`ifdef PREWISH_OVERRUN_CNT_EN
    ,
    .o_ovr_cnt (ovr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of masks, the mask being played and the clock position within
  // its 64-clock frame. The LED is simply bit (7 - position/8) of the current mask.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  logic       m_busy;
  int         m_phase;
  logic       m_prev_stb;
  logic       m_ack;
  int         m_ovr;

  task automatic model_reset();
    m_q.delete();
    m_cur      = 8'h00;
    m_busy     = 1'b0;
    m_phase    = 0;
    m_prev_stb = 1'b0;
    m_ack      = 1'b0;
    m_ovr      = 0;
  endtask

  task automatic model_step();
    logic req, pop_now, acc;
    req     = stb && !m_prev_stb;
    pop_now = (m_q.size() > 0) && (!m_busy || m_phase == 63);
    acc     = req && (m_q.size() < 4 || pop_now);
    if (!m_busy) begin
      if (m_q.size() > 0) begin
        m_cur   = m_q.pop_front();
        m_busy  = 1'b1;
        m_phase = 0;
      end
    end else if (m_phase == 63) begin
      m_phase = 0;
      if (m_q.size() > 0) m_cur = m_q.pop_front();
    end else begin
      m_phase = m_phase + 1;
    end
    if (acc) m_q.push_back(dat);
    m_ack = acc;
    if (req && !acc && m_ovr < 255) m_ovr = m_ovr + 1;
    m_prev_stb = stb;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Advance n cycles, comparing all outputs against the model at each falling edge.
  task automatic run_cycles(input int n, output int acks);
    logic [3:0] got, exp;
    acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp = {m_ack, (m_busy ? m_cur[7 - m_phase / 8] : 1'b0), m_busy, (m_q.size() == 4)};
      got = {ack, led, busy, full};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL model_cmp t=%0t {ack,led,busy,full}: got %b want %b", $time, got, exp);
      end
`ifdef PREWISH_OVERRUN_CNT_EN
      total++;
      if (ovr_cnt !== 8'(m_ovr)) begin
        bad++;
        $display("FAIL model_ovr t=%0t: got %0d want %0d", $time, ovr_cnt, m_ovr);
      end
`endif
      if (ack === 1'b1) acks++;
    end
  endtask

  task automatic do_reset();
    int a;
    stb   = 1'b0;
    rst_n = 1'b0;
    run_cycles(2, a);
    rst_n = 1'b1;
    run_cycles(1, a);
  endtask

  task automatic pulse(input logic [7:0] d, output int acks);
    int a1, a2;
    dat = d;
    stb = 1'b1;
    run_cycles(1, a1);
    stb = 1'b0;
    run_cycles(1, a2);
    acks = a1 + a2;
  endtask

  task automatic test_reset();
    int a;
    stb   = 1'b1;
    dat   = 8'h5A;
    rst_n = 1'b0;
    run_cycles(3, a);
    total++;
    if ({ack, led, busy, full} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000", {ack, led, busy, full});
    end
    rst_n = 1'b1;
    run_cycles(6, a);
    total++;
    if (a != 1) begin
      bad++;
      $display("FAIL stb_through_reset_acks: got %0d want 1", a);
    end
    stb = 1'b0;
    run_cycles(4, a);
  endtask

  task automatic test_single_pulse();
    int a;
    logic [7:0] pat;
    pat = 8'b10101000;
    do_reset();
    dat = pat;
    stb = 1'b1;
    run_cycles(1, a);
    total++;
    if (ack !== 1'b1) begin
      bad++;
      $display("FAIL t1_ack_at_plus1: got %b want 1", ack);
    end
    stb = 1'b0;
    for (int k = 0; k < 128; k++) begin
      run_cycles(1, a);
      total++;
      if (ack !== 1'b0 || led !== pat[7 - (k / 8) % 8]) begin
        bad++;
        $display("FAIL t1_pattern k=%0d: got ack=%b led=%b want ack=0 led=%b",
                 k, ack, led, pat[7 - (k / 8) % 8]);
      end
    end
  endtask

  task automatic test_held_strobe();
    int a;
    dat = 8'b11001010;
    stb = 1'b1;
    run_cycles(811, a);
    stb = 1'b0;
    total++;
    if (a != 1) begin
      bad++;
      $display("FAIL t2_held_acks: got %0d want 1", a);
    end
    run_cycles(130, a);
  endtask

  task automatic test_no_mid_frame_switch();
    int a;
    do_reset();
    pulse(8'hFF, a);
    run_cycles(3, a);
    pulse(8'b11100000, a);
    for (int k = 0; k < 50; k++) begin
      run_cycles(1, a);
      total++;
      if (led !== 1'b1) begin
        bad++;
        $display("FAIL t3_led_held k=%0d: got %b want 1", k, led);
      end
    end
    run_cycles(140, a);
  endtask

  task automatic test_full_and_pop_push();
    int a, acks, guard;
    do_reset();
    pulse(8'h81, a);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      pulse(8'h11 * 8'(i + 2), a);
      acks += a;
    end
    total++;
    if (acks != 4 || full !== 1'b1) begin
      bad++;
      $display("FAIL t4_fill: got acks=%0d full=%b want acks=4 full=1", acks, full);
    end
`ifdef PREWISH_OVERRUN_CNT_EN
    total++;
    if (ovr_cnt !== 8'd1) begin
      bad++;
      $display("FAIL t4_ovr: got %0d want 1", ovr_cnt);
    end
`endif
    guard = 0;
    while (!(m_busy && m_phase == 63) && guard < 200) begin
      run_cycles(1, a);
      guard++;
    end
    total++;
    if (guard >= 200) begin
      bad++;
      $display("FAIL t4_wait_frame_end: got timeout want frame end");
    end
    dat = 8'h3C;
    stb = 1'b1;
    run_cycles(1, a);
    total++;
    if (ack !== 1'b1 || full !== 1'b1) begin
      bad++;
      $display("FAIL t4_push_on_pop: got ack=%b full=%b want ack=1 full=1", ack, full);
    end
    stb = 1'b0;
    run_cycles(70, a);
  endtask

  task automatic test_reset_mid_frame();
    int a;
    do_reset();
    pulse(8'hFF, a);
    pulse(8'hA5, a);
    pulse(8'h5A, a);
    run_cycles(20, a);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ack, led, busy, full} !== 4'b0000) begin
      bad++;
      $display("FAIL t5_async_reset: got %b want 0000", {ack, led, busy, full});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      run_cycles(1, a);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL t5_idle_after_reset k=%0d: got %b want 0", k, busy);
      end
    end
    pulse(8'hC3, a);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL t5_busy_after_strobe: got %b want 1", busy);
    end
  endtask

`ifdef PREWISH_OVERRUN_CNT_EN
  task automatic test_ovr_saturate();
    int a;
    do_reset();
    for (int i = 0; i < 5; i++) pulse(8'(i + 1), a);
    for (int i = 0; i < 300; i++) pulse(8'(i), a);
    total++;
    if (ovr_cnt !== 8'hFF) begin
      bad++;
      $display("FAIL t6_ovr_saturate: got %0h want ff", ovr_cnt);
    end
  endtask
`endif

  task automatic test_random();
    int a;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        stb = ($urandom_range(0, 2) == 0);
        dat = 8'($urandom);
        run_cycles(1, a);
      end
    end
    stb = 1'b0;
    run_cycles(5, a);
  endtask

  initial begin
    stb   = 1'b0;
    dat   = 8'h00;
    rst_n = 1'b0;
    test_reset();
    test_single_pulse();
    test_held_strobe();
    test_no_mid_frame_switch();
    test_full_and_pop_push();
    test_reset_mid_frame();
`ifdef PREWISH_OVERRUN_CNT_EN
    test_ovr_saturate();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
